// File: rtl/snake_move_sched.sv
// Move scheduler for the snake game: queues button directions and issues one move per tick.
// Optional macro REVERSE_BLOCK_EN drops directions that would reverse the snake onto itself.
module snake_move_sched #(
  parameter int unsigned TICK_DIV = 34000000
) (
  input  logic       ClkPort,
  input  logic       Reset,
  input  logic       BtnU_p,
  input  logic       BtnD_p,
  input  logic       BtnL_p,
  input  logic       BtnR_p,
  input  logic       Start,
  input  logic       Move_ack,
  input  logic       Collision,
  output logic       Move_req,
  output logic [1:0] Move_dir,
  output logic       q_INI,
  output logic       q_RUN,
  output logic       q_WAIT,
  output logic       q_LOSE,
  output logic       Overrun
);

  localparam logic [3:0] INI  = 4'b0001;
  localparam logic [3:0] RUN  = 4'b0010;
  localparam logic [3:0] WAIT = 4'b0100;
  localparam logic [3:0] LOSE = 4'b1000;

  localparam int unsigned CW = 26;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    fifo0_q, fifo0_d;
  logic [1:0]    fifo1_q, fifo1_d;
  logic [1:0]    fill_q, fill_d;
  logic          armed_q, armed_d;
  logic          overrun_q, overrun_d;
  logic          move_req_q, move_req_d;
  logic [1:0]    dir_q, dir_d;

  logic       active, tc, fire, pop, push, take;
  logic       btn_any, dup, rev;
  logic [1:0] btn_dir, cmp_dir;

  assign active  = (state_q == RUN) || (state_q == WAIT);
  assign tc      = active && (cnt_q == CNT_LAST);
  assign fire    = (state_q == RUN) && tc && armed_q;
  assign pop     = fire && (fill_q != 2'd0);
  assign btn_any = BtnU_p | BtnD_p | BtnL_p | BtnR_p;

  always_comb begin
    btn_dir = 2'b11;
    if (BtnU_p)      btn_dir = 2'b00;
    else if (BtnD_p) btn_dir = 2'b01;
    else if (BtnL_p) btn_dir = 2'b10;
  end

  // Compare against the newest queued direction, or the heading if nothing is queued.
  always_comb begin
    cmp_dir = dir_q;
    if (fill_q == 2'd1)      cmp_dir = fifo0_q;
    else if (fill_q == 2'd2) cmp_dir = fifo1_q;
  end

  assign dup = (btn_dir == cmp_dir);
`ifdef REVERSE_BLOCK_EN
  assign rev = (btn_dir == {cmp_dir[1], ~cmp_dir[0]});
`else
  assign rev = 1'b0;
`endif

  // A pulse matching the heading is not queued but still counts as arming the game.
  assign take = active && btn_any && !rev;
  assign push = take && !dup && ((fill_q != 2'd2) || pop);

  always_comb begin
    fifo0_d = fifo0_q;
    fifo1_d = fifo1_q;
    fill_d  = fill_q;
    if (pop && push) begin
      if (fill_q == 2'd1) begin
        fifo0_d = btn_dir;
      end else begin
        fifo0_d = fifo1_q;
        fifo1_d = btn_dir;
      end
    end else if (pop) begin
      fifo0_d = fifo1_q;
      fill_d  = fill_q - 2'd1;
    end else if (push) begin
      if (fill_q == 2'd0) fifo0_d = btn_dir;
      else                fifo1_d = btn_dir;
      fill_d = fill_q + 2'd1;
    end
    if (!active) fill_d = 2'd0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INI:  state_d = RUN;
      RUN:  if (fire) state_d = WAIT;
      // The ack cannot belong to a request that is only now being presented.
      WAIT: if (Move_ack && !move_req_q) state_d = Collision ? LOSE : RUN;
      LOSE: if (Start) state_d = INI;
      default: state_d = INI;
    endcase
  end

  always_comb begin
    cnt_d      = '0;
    armed_d    = armed_q;
    overrun_d  = overrun_q;
    dir_d      = pop ? fifo0_q : dir_q;
    move_req_d = fire;
    if (active && !tc) cnt_d = cnt_q + 1'b1;
    if (state_q == INI) begin
      armed_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (take) armed_d = 1'b1;
      if ((state_q == WAIT) && tc) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state_q    <= INI;
      cnt_q      <= '0;
      fifo0_q    <= 2'b00;
      fifo1_q    <= 2'b00;
      fill_q     <= 2'd0;
      armed_q    <= 1'b0;
      overrun_q  <= 1'b0;
      move_req_q <= 1'b0;
      dir_q      <= 2'b11;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fifo0_q    <= fifo0_d;
      fifo1_q    <= fifo1_d;
      fill_q     <= fill_d;
      armed_q    <= armed_d;
      overrun_q  <= overrun_d;
      move_req_q <= move_req_d;
      dir_q      <= dir_d;
    end
  end

  assign Move_req = move_req_q;
  assign Move_dir = dir_q;
  assign Overrun  = overrun_q;
  assign q_INI    = state_q[0];
  assign q_RUN    = state_q[1];
  assign q_WAIT   = state_q[2];
  assign q_LOSE   = state_q[3];

endmodule

// File: tb/tb_snake_move_sched.sv
// Directed self-checking bench for snake_move_sched with TICK_DIV=8.
module tb_snake_move_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic       start = 1'b0, move_ack = 1'b0, collision = 1'b0;
  logic       move_req;
  logic [1:0] move_dir;
  logic       q_ini, q_run, q_wait, q_lose, overrun;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  snake_move_sched #(.TICK_DIV(8)) dut (
    .ClkPort  (clk),
    .Reset    (rst),
    .BtnU_p   (btn_u),
    .BtnD_p   (btn_d),
    .BtnL_p   (btn_l),
    .BtnR_p   (btn_r),
    .Start    (start),
    .Move_ack (move_ack),
    .Collision(collision),
    .Move_req (move_req),
    .Move_dir (move_dir),
    .q_INI    (q_ini),
    .q_RUN    (q_run),
    .q_WAIT   (q_wait),
    .q_LOSE   (q_lose),
    .Overrun  (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wire [3:0] st = {q_ini, q_run, q_wait, q_lose};

  task automatic pulse_btn(input int which);
    case (which)
      0: btn_u = 1'b1;
      1: btn_d = 1'b1;
      2: btn_l = 1'b1;
      default: btn_r = 1'b1;
    endcase
    @(negedge clk);
    {btn_u, btn_d, btn_l, btn_r} = 4'b0000;
  endtask

  task automatic wait_req(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (move_req === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Called one cycle after the request; ack lands two cycles after it.
  task automatic do_ack(input bit coll);
    @(negedge clk);
    move_ack = 1'b1;
    collision = coll;
    @(negedge clk);
    move_ack = 1'b0;
    collision = 1'b0;
  endtask

  task automatic req_and_ack(input string name, input logic [1:0] exp_dir, input bit coll);
    bit got;
    wait_req(20, got);
    tests++;
    if (!got) begin fails++; $display("FAIL %s_req: no Move_req within 20 cycles", name); end
    tests++;
    if (move_dir !== exp_dir) begin
      fails++; $display("FAIL %s_dir: got %b expected %b", name, move_dir, exp_dir);
    end
    @(negedge clk);
    do_ack(coll);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (st !== 4'b1000) begin fails++; $display("FAIL reset_state: got %b expected 1000", st); end
    tests++;
    if (move_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b expected 0", move_req); end
    tests++;
    if (move_dir !== 2'b11) begin fails++; $display("FAIL reset_dir: got %b expected 11", move_dir); end
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (st !== 4'b0100) begin fails++; $display("FAIL reset_to_run: got %b expected 0100", st); end
  endtask

  task automatic test_idle;
    bit bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (move_req !== 1'b0 || st !== 4'b0100) bad = 1'b1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL idle_unarmed: got move or state change, expected none"); end
  endtask

  task automatic test_move_right;
    bit got;
    int prev = 0;
    pulse_btn(3);
    for (int k = 0; k < 3; k++) begin
      wait_req(20, got);
      tests++;
      if (!got) begin fails++; $display("FAIL right_req%0d: no Move_req within 20 cycles", k); end
      tests++;
      if (move_dir !== 2'b11) begin
        fails++; $display("FAIL right_dir%0d: got %b expected 11", k, move_dir);
      end
      tests++;
      if (st !== 4'b0010) begin fails++; $display("FAIL right_wait%0d: got %b expected 0010", k, st); end
      if (k > 0) begin
        tests++;
        if (cyc - prev !== 8) begin
          fails++; $display("FAIL right_period%0d: got %0d expected 8", k, cyc - prev);
        end
      end
      prev = cyc;
      @(negedge clk);
      tests++;
      if (move_req !== 1'b0) begin fails++; $display("FAIL right_strobe%0d: got 1 expected 0", k); end
      do_ack(1'b0);
      tests++;
      if (st !== 4'b0100) begin fails++; $display("FAIL right_ack%0d: got %b expected 0100", k, st); end
    end
  endtask

  task automatic test_fifo_order;
    pulse_btn(0);
    pulse_btn(2);
    pulse_btn(1);
    req_and_ack("fifo_first", 2'b00, 1'b0);
    req_and_ack("fifo_second", 2'b10, 1'b0);
    req_and_ack("fifo_full_drop", 2'b10, 1'b0);
  endtask

  task automatic test_reversal;
    logic [1:0] exp;
    pulse_btn(0);
    req_and_ack("rev_setup_u", 2'b00, 1'b0);
    pulse_btn(3);
    req_and_ack("rev_setup_r", 2'b11, 1'b0);
`ifdef REVERSE_BLOCK_EN
    exp = 2'b11;
`else
    exp = 2'b10;
`endif
    pulse_btn(2);
    req_and_ack("rev_left", exp, 1'b0);
  endtask

  task automatic test_lose;
    bit bad = 1'b0;
    req_and_ack("lose_move", move_dir, 1'b1);
    tests++;
    if (st !== 4'b0001) begin fails++; $display("FAIL lose_state: got %b expected 0001", st); end
    pulse_btn(0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (move_req !== 1'b0 || st !== 4'b0001) bad = 1'b1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL lose_hold: got move or exit, expected none"); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (st !== 4'b1000) begin fails++; $display("FAIL lose_start_ini: got %b expected 1000", st); end
    @(negedge clk);
    tests++;
    if (st !== 4'b0100) begin fails++; $display("FAIL lose_start_run: got %b expected 0100", st); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (move_req !== 1'b0 || st !== 4'b0100) bad = 1'b1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL restart_unarmed: got move or state change, expected none"); end
  endtask

  task automatic test_overrun_reset;
    bit got;
    bit bad = 1'b0;
    pulse_btn(0);
    wait_req(20, got);
    tests++;
    if (!got) begin fails++; $display("FAIL ovr_req: no Move_req within 20 cycles"); end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (move_req !== 1'b0 || st !== 4'b0010) bad = 1'b1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL ovr_no_move: got move or state change in WAIT"); end
    tests++;
    if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    rst = 1'b1;
    #1;
    tests++;
    if (st !== 4'b1000) begin fails++; $display("FAIL midwait_rst_state: got %b expected 1000", st); end
    tests++;
    if (move_dir !== 2'b11) begin fails++; $display("FAIL midwait_rst_dir: got %b expected 11", move_dir); end
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL midwait_rst_ovr: got %b expected 0", overrun); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ack_ignored;
    move_ack = 1'b1;
    collision = 1'b1;
    @(negedge clk);
    move_ack = 1'b0;
    collision = 1'b0;
    @(negedge clk);
    tests++;
    if (st !== 4'b0100) begin fails++; $display("FAIL ack_in_run: got %b expected 0100", st); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_move_right();
    test_fifo_order();
    test_reversal();
    test_lose();
    test_overrun_reset();
    test_ack_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
